// File: rtl/vend_seq.sv
// vend_seq: four-product vending sequencer tracking coin credit, stock and change.
// Define VEND_TIMEOUT_EN to refund idle credit after TIMEOUT quiet cycles.
module vend_seq #(
  parameter int unsigned PRICE0     = 3,
  parameter int unsigned PRICE1     = 4,
  parameter int unsigned PRICE2     = 2,
  parameter int unsigned PRICE3     = 6,
  parameter int unsigned STOCK_MAX  = 7,
  parameter int unsigned CREDIT_MAX = 20,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin,
  input  logic       sel_valid,
  input  logic [1:0] sel,
  input  logic       cancel,
  input  logic       refill,
  output logic       vend,
  output logic [1:0] vend_id,
  output logic       change,
  output logic [4:0] credit,
  output logic       busy,
  output logic       coin_rej,
  output logic [3:0] sold_out
);

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    VEND,
    CHANGE
  } state_t;

  localparam logic [3:0] STOCK_FULL = 4'(STOCK_MAX);
  localparam logic [5:0] CREDIT_CAP = 6'(CREDIT_MAX);

  state_t          state;
  logic [3:0][3:0] stock;
  logic [4:0]      price;
  logic [1:0]      coin_units;
  logic [5:0]      credit_sum;
  logic            open_st;
  logic            do_cancel;
  logic            do_sel;
  logic            do_coin;
  logic            do_tmo;

  always_comb begin
    price = '0;
    unique case (sel)
      2'd0: price = 5'(PRICE0);
      2'd1: price = 5'(PRICE1);
      2'd2: price = 5'(PRICE2);
      2'd3: price = 5'(PRICE3);
    endcase
  end

  always_comb begin
    coin_units = 2'd0;
    unique case (coin)
      2'b01:   coin_units = 2'd1;
      2'b10:   coin_units = 2'd2;
      default: coin_units = 2'd0;
    endcase
  end

  // cancel beats a purchase, a purchase beats a coin
  assign open_st    = (state == IDLE) || (state == CREDIT);
  assign credit_sum = {1'b0, credit} + {4'd0, coin_units};
  assign do_cancel  = (state == CREDIT) && cancel;
  assign do_sel     = open_st && !do_cancel && sel_valid
                   && (credit >= price)
                   && (stock[sel] != 4'd0);
  assign do_coin    = open_st && !do_cancel && !do_sel
                   && (coin_units != 2'd0)
                   && (credit_sum <= CREDIT_CAP);

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] idle_cnt;
  logic          activity;

  assign activity = (coin != 2'b00) || sel_valid || cancel;
  assign do_tmo   = (state == CREDIT) && !activity
                 && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (rst || (state != CREDIT) || activity || do_tmo)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + TW'(1);
  end
`else
  localparam int unsigned unused_timeout = TIMEOUT;
  assign do_tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      credit   <= '0;
      stock    <= {4{STOCK_FULL}};
      vend     <= 1'b0;
      vend_id  <= 2'd0;
      change   <= 1'b0;
      busy     <= 1'b0;
      coin_rej <= 1'b0;
    end else begin
      vend     <= 1'b0;
      vend_id  <= 2'd0;
      change   <= 1'b0;
      coin_rej <= (coin != 2'b00) && !do_coin;
      busy     <= do_cancel || do_sel || do_tmo
               || ((state == VEND) && (credit != 5'd0))
               || ((state == CHANGE) && (credit > 5'd1));
      unique case (state)
        IDLE, CREDIT: begin
          if (refill && (state == IDLE))
            stock <= {4{STOCK_FULL}};
          unique case (1'b1)
            do_cancel: state <= CHANGE;
            do_tmo:    state <= CHANGE;
            do_sel: begin
              state      <= VEND;
              vend       <= 1'b1;
              vend_id    <= sel;
              credit     <= credit - price;
              stock[sel] <= stock[sel] - 4'd1;
            end
            do_coin: begin
              state  <= CREDIT;
              credit <= credit_sum[4:0];
            end
            default: ;
          endcase
        end
        VEND: begin
          state <= (credit != 5'd0) ? CHANGE : IDLE;
        end
        CHANGE: begin
          if (credit != 5'd0) begin
            change <= 1'b1;
            credit <= credit - 5'd1;
          end
          if (credit <= 5'd1)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    sold_out = '0;
    for (int i = 0; i < 4; i++)
      sold_out[i] = (stock[i] == 4'd0);
  end

endmodule

// File: tb/tb_vend_seq.sv
// tb_vend_seq: directed and random stimulus for vend_seq against a
// transaction-level model that scripts the expected output cycles.
module tb_vend_seq;

  localparam int TMO  = 8;
  localparam int CMAX = 20;
  localparam int SMAX = 7;

  typedef struct packed {
    logic       vend;
    logic [1:0] id;
    logic       change;
    logic [4:0] credit;
    logic       busy;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       refill;
  logic       vend;
  logic [1:0] vend_id;
  logic       change;
  logic [4:0] credit;
  logic       busy;
  logic       coin_rej;
  logic [3:0] sold_out;

  int   checks = 0;
  int   errors = 0;
  int   price [4] = '{3, 4, 2, 6};
  int   m_credit;
  int   m_stock [4];
  logic m_rej;
  obs_t cur;
  obs_t q [$];
`ifdef VEND_TIMEOUT_EN
  int   m_idle = 0;
`endif

  vend_seq #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .coin(coin),
    .sel_valid(sel_valid), .sel(sel),
    .cancel(cancel), .refill(refill),
    .vend(vend), .vend_id(vend_id),
    .change(change), .credit(credit),
    .busy(busy), .coin_rej(coin_rej),
    .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(logic v, logic [1:0] id,
                              logic ch, int cr, logic b);
    obs_t o;
    o.vend   = v;
    o.id     = id;
    o.change = ch;
    o.credit = 5'(cr);
    o.busy   = b;
    return o;
  endfunction

  // a refund shows one busy cycle holding the credit, then one pulse per unit
  task automatic refund(input int c);
    cur = mk(1'b0, 2'd0, 1'b0, c, 1'b1);
    for (int k = c - 1; k >= 0; k--)
      q.push_back(mk(1'b0, 2'd0, 1'b1, k, k > 0));
    m_credit = 0;
  endtask

  task automatic model(input logic r, input logic [1:0] c,
                       input logic v, input logic [1:0] s,
                       input logic cn, input logic rf);
    int units;
    int left;
    units = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 0;
    m_rej = 1'b0;
    if (r) begin
      cur = '0;
      q.delete();
      m_credit = 0;
      foreach (m_stock[i]) m_stock[i] = SMAX;
    end else if (q.size() > 0) begin
      cur   = q.pop_front();
      m_rej = (c != 2'b00);
    end else if (cn && m_credit > 0) begin
      m_rej = (c != 2'b00);
      refund(m_credit);
    end else if (v && m_credit >= price[s] && m_stock[s] > 0) begin
      m_rej = (c != 2'b00);
      left  = m_credit - price[s];
      m_stock[s]--;
      cur = mk(1'b1, s, 1'b0, left, 1'b1);
      if (left > 0)
        q.push_back(mk(1'b0, 2'd0, 1'b0, left, 1'b1));
      else
        q.push_back(mk(1'b0, 2'd0, 1'b0, 0, 1'b0));
      for (int k = left - 1; k >= 0; k--)
        q.push_back(mk(1'b0, 2'd0, 1'b1, k, k > 0));
      m_credit = 0;
    end else begin
      if (rf && m_credit == 0)
        foreach (m_stock[i]) m_stock[i] = SMAX;
      if (units > 0 && m_credit + units <= CMAX)
        m_credit += units;
      else if (c != 2'b00)
        m_rej = 1'b1;
      cur = mk(1'b0, 2'd0, 1'b0, m_credit, 1'b0);
`ifdef VEND_TIMEOUT_EN
      if (c != 2'b00 || v || cn || m_credit == 0) begin
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          m_idle = 0;
          refund(m_credit);
        end
      end
`endif
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] so;
    so = '0;
    foreach (m_stock[i]) so[i] = (m_stock[i] == 0);
    chk("vend", 8'(vend), 8'(cur.vend));
    chk("vend_id", 8'(vend_id), 8'(cur.id));
    chk("change", 8'(change), 8'(cur.change));
    chk("credit", 8'(credit), 8'(cur.credit));
    chk("busy", 8'(busy), 8'(cur.busy));
    chk("coin_rej", 8'(coin_rej), 8'(m_rej));
    chk("sold_out", 8'(sold_out), 8'(so));
  endtask

  task automatic step(input logic r, input logic [1:0] c,
                      input logic v, input logic [1:0] s,
                      input logic cn, input logic rf);
    rst = r; coin = c; sel_valid = v;
    sel = s; cancel = cn; refill = rf;
    model(r, c, v, s, cn, rf);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic put(input logic [1:0] c);
    step(1'b0, c, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic pick(input logic [1:0] s);
    step(1'b0, 2'b00, 1'b1, s, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      idle();
      n++;
    end
    chk("drain_busy", 8'(busy), 8'd0);
  endtask

  initial begin
    int n;
    step(1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("rst_credit", 8'(credit), 8'd0);
    chk("rst_sold_out", 8'(sold_out), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);

    put(2'b01); chk("c38_1", 8'(credit), 8'd1);
    put(2'b01); chk("c38_2", 8'(credit), 8'd2);
    put(2'b01); chk("c38_3", 8'(credit), 8'd3);
    pick(2'd0);
    chk("v38", 8'(vend), 8'd1);
    chk("id38", 8'(vend_id), 8'd0);
    chk("cr38", 8'(credit), 8'd0);
    idle();
    chk("idle38", 8'(busy), 8'd0);
    chk("noch38", 8'(change), 8'd0);

    put(2'b10); put(2'b10);
    chk("cr39", 8'(credit), 8'd4);
    pick(2'd2);
    chk("id39", 8'(vend_id), 8'd2);
    chk("left39", 8'(credit), 8'd2);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (change === 1'b1) n++;
    end
    chk("pulses39", 8'(n), 8'd2);
    chk("end39", 8'(credit), 8'd0);

    put(2'b01); put(2'b10);
    pick(2'd3);
    chk("ign40", 8'(vend), 8'd0);
    chk("cr40", 8'(credit), 8'd3);
    step(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      idle();
      if (change === 1'b1) n++;
    end
    chk("pulses40", 8'(n), 8'd3);
    chk("end40", 8'(credit), 8'd0);

    for (int i = 0; i < 9; i++) put(2'b10);
    put(2'b01);
    chk("cr41", 8'(credit), 8'd19);
    put(2'b10);
    chk("rej41", 8'(coin_rej), 8'd1);
    chk("hold41", 8'(credit), 8'd19);
    step(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    drain();
    put(2'b11);
    chk("rej41b", 8'(coin_rej), 8'd1);
    chk("cr41b", 8'(credit), 8'd0);

    for (int i = 0; i < 7; i++) begin
      put(2'b10); put(2'b10);
      pick(2'd1);
      drain();
    end
    chk("so42", 8'(sold_out), 8'h02);
    put(2'b10); put(2'b10);
    pick(2'd1);
    chk("ign42", 8'(vend), 8'd0);
    chk("cr42", 8'(credit), 8'd4);
    step(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    drain();
    step(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("refill42", 8'(sold_out), 8'h00);

    put(2'b10); put(2'b10);
    step(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    idle();
    chk("mid43", 8'(change), 8'd1);
    step(1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("rst43_cr", 8'(credit), 8'd0);
    chk("rst43_ch", 8'(change), 8'd0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      if (change === 1'b1) n++;
    end
    chk("rst43_pulses", 8'(n), 8'd0);

`ifdef VEND_TIMEOUT_EN
    put(2'b01);
    n = 0;
    while (busy !== 1'b1 && n < 40) begin
      idle();
      n++;
    end
    chk("tmo_latency", 8'(n), 8'(TMO));
    idle();
    chk("tmo_change", 8'(change), 8'd1);
    drain();
`endif

    for (int i = 0; i < 3000; i++) begin
      logic       r;
      logic [1:0] c;
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      step(r, c,
           $urandom_range(0, 3) == 0,
           2'($urandom_range(0, 3)),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 19) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
